// File: rtl/bus_ctrl_pkg.sv
// Shared types for the bus controller slice: op-code encoding, decoder
// state enum and the classified strobe pattern enum.
package bus_ctrl_pkg;

  localparam logic [2:0] OP_NONE   = 3'd0;
  localparam logic [2:0] OP_SWAP   = 3'd1;
  localparam logic [2:0] OP_MOVE   = 3'd2;
  localparam logic [2:0] OP_LOADR1 = 3'd3;
  localparam logic [2:0] OP_LOADR2 = 3'd4;
  localparam logic [2:0] OP_LOADR3 = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SW1,
    ST_SW2,
    ST_SW3
  } dec_state_t;

  typedef enum logic [2:0] {
    PAT_IDLE,
    PAT_MV,
    PAT_L1,
    PAT_L2,
    PAT_L3,
    PAT_S1,
    PAT_S3,
    PAT_ILLEGAL
  } bus_pat_t;

endpackage

// File: rtl/bus_pattern_classify.sv
// Purely combinational classifier: maps the seven bus strobes onto a
// pattern enum and flags more than one bus driver in the same cycle.
module bus_pattern_classify
  import bus_ctrl_pkg::*;
(
  input  logic     i_R1out,
  input  logic     i_R2out,
  input  logic     i_R3out,
  input  logic     i_R1in,
  input  logic     i_R2in,
  input  logic     i_R3in,
  input  logic     i_Extern,
  output bus_pat_t o_pattern,
  output logic     o_contention
);

  logic [6:0] w_strobes;
  logic [3:0] w_drivers;

  assign w_strobes = {i_R1out, i_R2out, i_R3out, i_R1in, i_R2in, i_R3in, i_Extern};
  assign w_drivers = {i_R1out, i_R2out, i_R3out, i_Extern};

  // x & (x-1) clears the lowest set bit, so it is nonzero only for 2+ drivers
  assign o_contention = (w_drivers & (w_drivers - 4'd1)) != 4'd0;

  always_comb begin
    o_pattern = PAT_ILLEGAL;
    case (w_strobes)
      7'b000_000_0: o_pattern = PAT_IDLE;
      7'b100_010_0: o_pattern = PAT_MV;
      7'b000_100_1: o_pattern = PAT_L1;
      7'b000_010_1: o_pattern = PAT_L2;
      7'b000_001_1: o_pattern = PAT_L3;
      7'b010_001_0: o_pattern = PAT_S1;
      7'b001_100_0: o_pattern = PAT_S3;
      default:      o_pattern = PAT_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/bus_op_decoder.sv
// Watches the bus control strobes and reports completed register operations
// and protocol errors. Define BUS_OP_DECODER_STATS_EN to add op/err counters.
module bus_op_decoder
  import bus_ctrl_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         Clock,
  input  logic         reset,
  input  logic         R1out,
  input  logic         R2out,
  input  logic         R3out,
  input  logic         R1in,
  input  logic         R2in,
  input  logic         R3in,
  input  logic         Extern,
  input  logic [N-1:0] BusWires,
  output logic         op_valid,
  output logic [2:0]   op_code,
  output logic [N-1:0] op_data,
  output logic         err_contention,
  output logic         err_illegal,
  output logic         err_swap_abort
`ifdef BUS_OP_DECODER_STATS_EN
  ,
  output logic [15:0]  op_count,
  output logic [7:0]   err_count
`endif
);

  dec_state_t     r_state;
  dec_state_t     w_nextState;
  bus_pat_t       w_pattern;
  logic           w_contention;
  logic           w_fresh;
  logic [2:0]     w_opCode;
  logic           w_errIllegal;
  logic           w_errAbort;

  logic           r_opValid;
  logic [2:0]     r_opCode;
  logic [N-1:0]   r_opData;
  logic           r_errContention;
  logic           r_errIllegal;
  logic           r_errAbort;

  bus_pattern_classify u_classify (
    .i_R1out      (R1out),
    .i_R2out      (R2out),
    .i_R3out      (R3out),
    .i_R1in       (R1in),
    .i_R2in       (R2in),
    .i_R3in       (R3in),
    .i_Extern     (Extern),
    .o_pattern    (w_pattern),
    .o_contention (w_contention)
  );

  // The pattern is decoded as if idle unless it continues the swap in progress
  assign w_fresh = (r_state == ST_IDLE) ||
                   (r_state == ST_SW1 && w_pattern != PAT_MV) ||
                   (r_state == ST_SW2 && w_pattern != PAT_S3) ||
                   (r_state == ST_SW3 && w_pattern != PAT_S3);

  always_ff @(posedge Clock) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = ST_IDLE;
    if (w_fresh) begin
      w_nextState = (w_pattern == PAT_S1) ? ST_SW1 : ST_IDLE;
    end else begin
      case (r_state)
        ST_SW1:  w_nextState = ST_SW2;
        ST_SW2:  w_nextState = ST_SW3;
        ST_SW3:  w_nextState = ST_SW3;
        default: w_nextState = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_opCode     = OP_NONE;
    w_errIllegal = 1'b0;
    w_errAbort   = w_fresh && (r_state == ST_SW1 || r_state == ST_SW2);
    if (w_fresh) begin
      case (w_pattern)
        PAT_MV:      w_opCode = OP_MOVE;
        PAT_L1:      w_opCode = OP_LOADR1;
        PAT_L2:      w_opCode = OP_LOADR2;
        PAT_L3:      w_opCode = OP_LOADR3;
        PAT_S3:      w_errIllegal = 1'b1;
        PAT_ILLEGAL: w_errIllegal = 1'b1;
        default:     w_opCode = OP_NONE;
      endcase
    end else if (r_state == ST_SW2) begin
      w_opCode = OP_SWAP;
    end
  end

  // op_data only reloads on a completing op, so it holds between ops
  always_ff @(posedge Clock) begin
    if (reset) begin
      r_opValid       <= 1'b0;
      r_opCode        <= OP_NONE;
      r_opData        <= '0;
      r_errContention <= 1'b0;
      r_errIllegal    <= 1'b0;
      r_errAbort      <= 1'b0;
    end else begin
      r_opValid       <= (w_opCode != OP_NONE);
      r_opCode        <= w_opCode;
      if (w_opCode != OP_NONE) r_opData <= BusWires;
      r_errContention <= w_contention;
      r_errIllegal    <= w_errIllegal;
      r_errAbort      <= w_errAbort;
    end
  end

  assign op_valid       = r_opValid;
  assign op_code        = r_opCode;
  assign op_data        = r_opData;
  assign err_contention = r_errContention;
  assign err_illegal    = r_errIllegal;
  assign err_swap_abort = r_errAbort;

`ifdef BUS_OP_DECODER_STATS_EN
  logic [15:0] r_opCount;
  logic [7:0]  r_errCount;

  // Counters follow the registered pulses and stick at all-ones
  always_ff @(posedge Clock) begin
    if (reset) begin
      r_opCount  <= '0;
      r_errCount <= '0;
    end else begin
      if (r_opValid && r_opCount != 16'hFFFF) r_opCount <= r_opCount + 16'd1;
      if ((r_errContention || r_errIllegal || r_errAbort) && r_errCount != 8'hFF)
        r_errCount <= r_errCount + 8'd1;
    end
  end

  assign op_count  = r_opCount;
  assign err_count = r_errCount;
`endif

endmodule

// File: tb/tb_bus_op_decoder.sv
// Scoreboard bench for bus_op_decoder: stimulus pushes hand-computed expected
// output events, a negedge monitor pops and compares them as the DUT reports.
module tb_bus_op_decoder;

  localparam logic [6:0] P_IDLE = 7'b000_000_0;
  localparam logic [6:0] P_MV   = 7'b100_010_0;
  localparam logic [6:0] P_L1   = 7'b000_100_1;
  localparam logic [6:0] P_L2   = 7'b000_010_1;
  localparam logic [6:0] P_L3   = 7'b000_001_1;
  localparam logic [6:0] P_S1   = 7'b010_001_0;
  localparam logic [6:0] P_S3   = 7'b001_100_0;
  localparam logic [6:0] P_CONT = 7'b110_010_0;

  typedef struct {
    int         cyc;
    logic [14:0] ev;
  } exp_t;

  logic       Clock = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] strobes = 7'b0;
  logic [7:0] busWires = 8'h00;
  logic       opValid;
  logic [2:0] opCode;
  logic [7:0] opData;
  logic       errContention;
  logic       errIllegal;
  logic       errSwapAbort;
`ifdef BUS_OP_DECODER_STATS_EN
  logic [15:0] opCount;
  logic [7:0]  errCount;
`endif

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  logic [7:0] lastData = 8'h00;
  exp_t expQ[$];

  bus_op_decoder #(.N(8)) dut (
    .Clock          (Clock),
    .reset          (reset),
    .R1out          (strobes[6]),
    .R2out          (strobes[5]),
    .R3out          (strobes[4]),
    .R1in           (strobes[3]),
    .R2in           (strobes[2]),
    .R3in           (strobes[1]),
    .Extern         (strobes[0]),
    .BusWires       (busWires),
    .op_valid       (opValid),
    .op_code        (opCode),
    .op_data        (opData),
    .err_contention (errContention),
    .err_illegal    (errIllegal),
    .err_swap_abort (errSwapAbort)
`ifdef BUS_OP_DECODER_STATS_EN
    ,
    .op_count       (opCount),
    .err_count      (errCount)
`endif
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total = total + 1;
    if (act !== req) begin
      bad = bad + 1;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // One bus cycle; when expEv is set, the event {valid,code,data,cont,ill,abort} is queued
  task automatic applyStimulus(input logic [6:0] s, input logic [7:0] bus, input logic rst,
                               input bit expEv, input logic [2:0] code,
                               input logic c, input logic i, input logic a);
    exp_t e;
    @(negedge Clock);
    strobes  = s;
    busWires = bus;
    reset    = rst;
    if (rst) lastData = 8'h00;
    else if (code != 3'd0) lastData = bus;
    if (expEv) begin
      e.cyc = cyc + 1;
      e.ev  = {code != 3'd0, code, lastData, c, i, a};
      expQ.push_back(e);
    end
  endtask

  always @(negedge Clock) begin
    logic anyOut;
    exp_t e;
    anyOut = opValid | errContention | errIllegal | errSwapAbort;
    if (anyOut) begin
      if (expQ.size() == 0 || expQ[0].cyc != cyc) begin
        checkOutput("unexpected_output", {17'd0, opValid, opCode, opData, errContention, errIllegal, errSwapAbort}, 32'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput("event", {17'd0, opValid, opCode, opData, errContention, errIllegal, errSwapAbort}, {17'd0, e.ev});
      end
    end else if (expQ.size() > 0 && expQ[0].cyc <= cyc) begin
      e = expQ.pop_front();
      checkOutput("missed_event", 32'd0, {17'd0, e.ev});
    end
  end

  initial begin
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    checkOutput("reset_outputs", {17'd0, opValid, opCode, opData, errContention, errIllegal, errSwapAbort}, 32'd0);

    applyStimulus(P_L2,   8'h5A, 1'b0, 1, 3'd4, 0, 0, 0);
    applyStimulus(P_IDLE, 8'h00, 1'b0, 0, 3'd0, 0, 0, 0);

    applyStimulus(P_S1,   8'h11, 1'b0, 0, 3'd0, 0, 0, 0);
    applyStimulus(P_MV,   8'h22, 1'b0, 0, 3'd0, 0, 0, 0);
    applyStimulus(P_S3,   8'h33, 1'b0, 1, 3'd1, 0, 0, 0);
    applyStimulus(P_S3,   8'h44, 1'b0, 0, 3'd0, 0, 0, 0);
    applyStimulus(P_S3,   8'h55, 1'b0, 0, 3'd0, 0, 0, 0);
    applyStimulus(P_IDLE, 8'h00, 1'b0, 0, 3'd0, 0, 0, 0);

    applyStimulus(P_S1,   8'h00, 1'b0, 0, 3'd0, 0, 0, 0);
    applyStimulus(P_L1,   8'h7E, 1'b0, 1, 3'd3, 0, 0, 1);
    applyStimulus(P_IDLE, 8'h00, 1'b0, 0, 3'd0, 0, 0, 0);

    applyStimulus(P_CONT, 8'h99, 1'b0, 1, 3'd0, 1, 1, 0);
    applyStimulus(P_S3,   8'h12, 1'b0, 1, 3'd0, 0, 1, 0);

    applyStimulus(P_S1,   8'h00, 1'b0, 0, 3'd0, 0, 0, 0);
    applyStimulus(P_CONT, 8'h01, 1'b0, 1, 3'd0, 1, 1, 1);

    applyStimulus(P_S1,   8'h00, 1'b0, 0, 3'd0, 0, 0, 0);
    applyStimulus(P_MV,   8'h00, 1'b0, 0, 3'd0, 0, 0, 0);
    applyStimulus(P_L3,   8'h21, 1'b0, 1, 3'd5, 0, 0, 1);

    applyStimulus(P_S1,   8'h00, 1'b0, 0, 3'd0, 0, 0, 0);
    applyStimulus(P_MV,   8'h00, 1'b0, 0, 3'd0, 0, 0, 0);
    applyStimulus(P_IDLE, 8'h00, 1'b0, 1, 3'd0, 0, 0, 1);

    applyStimulus(P_S1,   8'h00, 1'b0, 0, 3'd0, 0, 0, 0);
    applyStimulus(P_S1,   8'h00, 1'b0, 1, 3'd0, 0, 0, 1);
    applyStimulus(P_MV,   8'h00, 1'b0, 0, 3'd0, 0, 0, 0);
    applyStimulus(P_S3,   8'h66, 1'b0, 1, 3'd1, 0, 0, 0);
    applyStimulus(P_L1,   8'h02, 1'b0, 1, 3'd3, 0, 0, 0);
    applyStimulus(P_MV,   8'h44, 1'b0, 1, 3'd2, 0, 0, 0);
    applyStimulus(P_IDLE, 8'h00, 1'b0, 0, 3'd0, 0, 0, 0);

    applyStimulus(P_S1,   8'h00, 1'b0, 0, 3'd0, 0, 0, 0);
    applyStimulus(P_MV,   8'h00, 1'b0, 0, 3'd0, 0, 0, 0);
    applyStimulus(P_S3,   8'hAB, 1'b1, 0, 3'd0, 0, 0, 0);
    applyStimulus(P_MV,   8'h3C, 1'b0, 1, 3'd2, 0, 0, 0);
    applyStimulus(P_IDLE, 8'h00, 1'b0, 0, 3'd0, 0, 0, 0);
    applyStimulus(P_IDLE, 8'h00, 1'b0, 0, 3'd0, 0, 0, 0);
    checkOutput("data_hold", {24'd0, opData}, 32'h3C);

`ifdef BUS_OP_DECODER_STATS_EN
    applyStimulus(P_IDLE, 8'h00, 1'b1, 0, 3'd0, 0, 0, 0);
    applyStimulus(P_L1,   8'h01, 1'b0, 1, 3'd3, 0, 0, 0);
    applyStimulus(P_L2,   8'h02, 1'b0, 1, 3'd4, 0, 0, 0);
    applyStimulus(P_L3,   8'h03, 1'b0, 1, 3'd5, 0, 0, 0);
    applyStimulus(P_S3,   8'h04, 1'b0, 1, 3'd0, 0, 1, 0);
    repeat (3) applyStimulus(P_IDLE, 8'h00, 1'b0, 0, 3'd0, 0, 0, 0);
    @(negedge Clock);
    checkOutput("op_count_3", {16'd0, opCount}, 32'd3);
    checkOutput("err_count_1", {24'd0, errCount}, 32'd1);
    for (int k = 0; k < 70000; k++) applyStimulus(P_MV, 8'h5C, 1'b0, 1, 3'd2, 0, 0, 0);
    repeat (3) applyStimulus(P_IDLE, 8'h00, 1'b0, 0, 3'd0, 0, 0, 0);
    @(negedge Clock);
    checkOutput("op_count_sat", {16'd0, opCount}, 32'h0000FFFF);
`endif

    repeat (3) applyStimulus(P_IDLE, 8'h00, 1'b0, 0, 3'd0, 0, 0, 0);
    @(negedge Clock);
    checkOutput("queue_drained", expQ.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
